// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// The instruction field positions are shared with the decoder.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int IMM_W   = 16;

    typedef enum logic {
        S_REQ   = 1'b0,
        S_ISSUE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    import instr_fetch_pkg::*;

    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Sequential-PC and branch-target computation, shared with the datapath branch unit.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_next
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_offset,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] branch_disp;

    // Word offset: sign-extend imm16 and scale by 4.
    assign branch_disp = {{(ADDR_W-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};
    assign pc_plus4    = pc + ADDR_W'(4);
    assign next_pc     = branch_taken ? (pc_plus4 + branch_disp) : pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the multi-cycle MIPS core: holds the PC, fetches words over the
// imem req/ack bus and presents them in the instruction register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_offset,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         func,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              req;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    // req is low for the first cycle after reset, so an ack arriving then is
    // ignored; it is raised on that first edge and held until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            instr       <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            req         <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req && imem.ack) begin
                        instr       <= imem.rdata;
                        pc          <= fetch_pc;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        state       <= S_ISSUE;
                    end else begin
                        req <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        fetch_pc    <= next_pc;
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc;
    assign op        = instr[OP_HI:OP_LO];
    assign func      = instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: handshake timing, stalls, branches, wrap and reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks   = 0;
    int failures = 0;

    instr_fetch_if #(.ADDR_W(32)) imem ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem.master),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr         (instr),
        .op            (op),
        .func          (func),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ack, input logic [31:0] rdata, input logic stl,
                                  input logic taken, input logic [15:0] offset);
        imem.ack      = ack;
        imem.rdata    = rdata;
        stall         = stl;
        branch_taken  = taken;
        branch_offset = offset;
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr, input logic valid);
        check_output({tag, "_req"},   {31'd0, imem.req}, {31'd0, req});
        check_output({tag, "_addr"},  imem.addr, addr);
        check_output({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        check_fetch("reset", 1'b0, 32'h0, 1'b0);
        check_output("reset_op",       {26'd0, op},   32'h0);
        check_output("reset_func",     {26'd0, func}, 32'h0);
        check_output("reset_pc",       pc,            32'h0);
        check_output("reset_pc_plus4", pc_plus4,      32'h4);
        check_output("reset_instr",    instr,         32'h0);

        // Ack on the very first request cycle.
        rst = 1'b0;
        step();
        check_fetch("first_req", 1'b1, 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0020, 1'b0, 1'b0, 16'h0);
        step();
        check_fetch("add_cap", 1'b0, 32'h0, 1'b1);
        check_output("add_op",    {26'd0, op},   32'h0);
        check_output("add_func",  {26'd0, func}, 32'h20);
        check_output("add_pc",    pc,            32'h0);
        check_output("add_instr", instr,         32'h0000_0020);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_fetch("req4", 1'b1, 32'h4, 1'b0);

        apply_stimulus(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 16'h0);
        step();
        check_output("lw_op", {26'd0, op}, 32'h23);
        check_output("lw_pc", pc,          32'h4);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        step();

        // Delayed ack: request and address must stay put.
        for (int i = 0; i < 3; i++) begin
            check_fetch($sformatf("wait%0d", i), 1'b1, 32'h8, 1'b0);
            step();
        end
        check_fetch("wait3", 1'b1, 32'h8, 1'b0);
        apply_stimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 16'h0);
        step();
        check_fetch("beq_cap", 1'b0, 32'h8, 1'b1);
        check_output("beq_pc",    pc,    32'h8);
        check_output("beq_instr", instr, 32'h1000_0003);

        // Stall with noise on branch inputs and a stray ack while req is low.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1, i[0], 16'hFFFF);
            step();
            check_fetch($sformatf("stall%0d", i), 1'b0, 32'h8, 1'b1);
            check_output($sformatf("stall%0d_instr", i), instr, 32'h1000_0003);
            check_output($sformatf("stall%0d_pc", i),    pc,    32'h8);
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_fetch("after_stall", 1'b1, 32'hC, 1'b0);

        // Branch from 0xC: 0x10 + 0x3C*4 = 0x100.
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'h003C);
        step();
        check_fetch("br_to_100", 1'b1, 32'h100, 1'b0);
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_output("pc_100", pc, 32'h100);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'hFFFF);
        step();
        check_fetch("br_neg1", 1'b1, 32'h100, 1'b0);
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'h0003);
        step();
        check_fetch("br_plus3", 1'b1, 32'h110, 1'b0);

        // Branch from 0x110 to 0xFFFF_FFFC: 0x114 - 0x118.
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'hFFBA);
        step();
        check_fetch("br_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_output("top_pc",       pc,       32'hFFFF_FFFC);
        check_output("top_pc_plus4", pc_plus4, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1, ~i[0], 16'h0040);
            step();
            check_fetch($sformatf("top_stall%0d", i), 1'b0, 32'hFFFF_FFFC, 1'b1);
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0040);
        step();
        check_fetch("wrap", 1'b1, 32'h0, 1'b0);

        // Reset in the middle of an outstanding request; late ack ignored.
        step();
        rst = 1'b1;
        apply_stimulus(1'b1, 32'hFC00_003F, 1'b0, 1'b0, 16'h0);
        #1;
        check_output("rst_req_drop", {31'd0, imem.req}, 32'h0);
        step();
        rst = 1'b0;
        step();
        check_fetch("post_rst", 1'b1, 32'h0, 1'b0);
        check_output("post_rst_op", {26'd0, op}, 32'h0);
        step();
        check_fetch("post_rst_cap", 1'b0, 32'h0, 1'b1);
        check_output("post_rst_op2", {26'd0, op}, 32'h3F);
        check_output("post_rst_pc",  pc,          32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
